// File: rtl/segre_mm_responder.sv
// Main-memory responder for the MMU refill / write-through path.
// Serves one lane read or sub-word write at a time after a fixed latency.
module segre_mm_responder #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int MEM_LANES = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_i,
    input  logic                 wr_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [31:0]          wr_data_i,
    input  logic [1:0]           wr_data_type_i,
    output logic [LANE_SIZE-1:0] data_o,
    output logic                 data_rdy_o,
    output logic                 busy_o
);

    localparam int         LANE_BYTES = LANE_SIZE / 8;
    localparam int         IDX_W      = $clog2(MEM_LANES);
    localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
    localparam bit         ONE_CYCLE  = (LATENCY == 1);

    localparam logic [1:0] MEMOP_BYTE = 2'd0;
    localparam logic [1:0] MEMOP_HALF = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               is_rd_q, is_rd_d;
    logic               is_wr_q, is_wr_d;
    logic [IDX_W-1:0]   lane_q, lane_d;
    logic [3:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         wtype_q, wtype_d;
    logic [LANE_SIZE-1:0] data_q;

    logic [LANE_SIZE-1:0]  mem_q [MEM_LANES];
    logic [LANE_BYTES-1:0] wr_be;
    logic [LANE_SIZE-1:0]  wr_lane;
    logic [3:0]            rel;
    logic                  enter_resp;
    logic                  addr_hi_unused;

    // Lane index aliases modulo MEM_LANES, so the upper address bits are dropped.
    assign addr_hi_unused = ^addr_i[ADDR_SIZE-1:4+IDX_W];

    // Start byte of the access; misaligned HALF/WORD offsets are forced down.
    function automatic logic [3:0] align_off(input logic [3:0] off, input logic [1:0] dtype);
        case (dtype)
            MEMOP_BYTE: align_off = off;
            MEMOP_HALF: align_off = {off[3:1], 1'b0};
            default:    align_off = {off[3:2], 2'b00};
        endcase
    endfunction

    // Access size in bytes; the illegal encoding behaves as WORD.
    function automatic logic [3:0] type_bytes(input logic [1:0] dtype);
        case (dtype)
            MEMOP_BYTE: type_bytes = 4'd1;
            MEMOP_HALF: type_bytes = 4'd2;
            default:    type_bytes = 4'd4;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        is_wr_d = is_wr_q;
        lane_d  = lane_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wtype_d = wtype_q;
        case (state_q)
            IDLE: begin
                if (rd_i || wr_i) begin
                    // A simultaneous write is left pending for the requester.
                    is_rd_d = rd_i;
                    is_wr_d = ~rd_i;
                    lane_d  = addr_i[4 +: IDX_W];
                    off_d   = addr_i[3:0];
                    wdata_d = wr_data_i;
                    wtype_d = wr_data_type_i;
                    cnt_d   = CNT_LOAD;
                    state_d = ONE_CYCLE ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d  = (state_d == RESP);
        busy_d = (state_d != IDLE);
    end

    // The _d request fields equal the held ones in WAIT, and carry the fresh
    // request when a single-cycle latency enters RESP straight from IDLE.
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        wr_be   = '0;
        wr_lane = '0;
        rel     = '0;
        for (int b = 0; b < LANE_BYTES; b++) begin
            rel                = 4'(b) - align_off(off_d, wtype_d);
            wr_be[b]           = (rel < type_bytes(wtype_d));
            wr_lane[8*b +: 8]  = wdata_d[{rel[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            is_rd_q <= 1'b0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            is_rd_q <= is_rd_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        lane_q  <= lane_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
        wtype_q <= wtype_d;
    end

    // Write commit and read capture both happen on the edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && is_wr_d) begin
            for (int b = 0; b < LANE_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[lane_d][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (enter_resp && is_rd_d) begin
            data_q <= mem_q[lane_d];
        end
    end

    assign data_o     = data_q;
    assign data_rdy_o = rdy_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_segre_mm_responder.sv
// Directed bench for segre_mm_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_segre_mm_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         rd0, wr0, rd1, wr1;
    logic [31:0]  addr0, wd0, addr1, wd1;
    logic [1:0]   wt0, wt1;
    logic [127:0] do0, do1;
    logic         rdy0, busy0, rdy1, busy1;

    int n_cmp = 0;
    int n_mis = 0;

    segre_mm_responder #(.ADDR_SIZE(32), .LANE_SIZE(128), .MEM_LANES(1024), .LATENCY(4)) dut (
        .clk_i(clk), .rst_i(rst), .rd_i(rd0), .wr_i(wr0), .addr_i(addr0),
        .wr_data_i(wd0), .wr_data_type_i(wt0), .data_o(do0), .data_rdy_o(rdy0), .busy_o(busy0)
    );

    segre_mm_responder #(.ADDR_SIZE(32), .LANE_SIZE(128), .MEM_LANES(1024), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .rd_i(rd1), .wr_i(wr1), .addr_i(addr1),
        .wr_data_i(wd1), .wr_data_type_i(wt1), .data_o(do1), .data_rdy_o(rdy1), .busy_o(busy1)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until data_rdy_o, report latency and busy cycles.
    task automatic do_req(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] typ,
                          output int lat, output int bcyc);
        bit seen;
        @(negedge clk);
        if (sel) begin
            rd1 = rd; wr1 = wr; addr1 = addr; wd1 = data; wt1 = typ;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = addr; wd0 = data; wt0 = typ;
        end
        lat  = -1;
        bcyc = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (sel ? busy1 : busy0) bcyc++;
            if (sel ? rdy1 : rdy0) begin
                lat  = n;
                seen = 1'b1;
            end
        end
        if (sel) begin
            rd1 = 1'b0; wr1 = 1'b0;
        end else begin
            rd0 = 1'b0; wr0 = 1'b0;
        end
        @(negedge clk);
        check_val("rdy_pulse_width", 128'(sel ? rdy1 : rdy0), 128'd0);
    endtask

    task automatic zero_lane(input bit sel, input logic [31:0] base);
        int lat, bcyc;
        for (int w = 0; w < 4; w++) begin
            do_req(sel, 1'b0, 1'b1, base + 32'(4 * w), 32'h0, 2'd2, lat, bcyc);
        end
    endtask

    initial begin
        int  lat, bcyc;
        logic [127:0] acc_do;
        logic acc_rdy, acc_busy, seen_rdy;
        logic [5:0] rdy_pat, busy_pat;

        rst = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; wt0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; wt1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        acc_do = '0; acc_rdy = 1'b0; acc_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc_do   = acc_do | do0;
            acc_rdy  = acc_rdy | rdy0;
            acc_busy = acc_busy | busy0;
        end
        check_val("idle_data", acc_do, 128'd0);
        check_val("idle_rdy", 128'(acc_rdy), 128'd0);
        check_val("idle_busy", 128'(acc_busy), 128'd0);
        check_val("idle_data_l1", do1, 128'd0);

        // WORD write then lane read
        zero_lane(1'b0, 32'h10);
        do_req(1'b0, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 2'd2, lat, bcyc);
        check_val("wr_latency", 128'(lat), 128'd4);
        check_val("wr_busy_cycles", 128'(bcyc), 128'd4);
        check_val("wr_keeps_data", do0, 128'd0);
        do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, lat, bcyc);
        check_val("rd_latency", 128'(lat), 128'd4);
        check_val("rd_busy_cycles", 128'(bcyc), 128'd4);
        check_val("rd_word_lane", do0, {64'h0, 32'hDEADBEEF, 32'h0});

        // BYTE / HALF merge into a zeroed lane; upper write bits must be ignored
        zero_lane(1'b0, 32'h20);
        do_req(1'b0, 1'b0, 1'b1, 32'h23, 32'hFFFFFFAA, 2'd0, lat, bcyc);
        do_req(1'b0, 1'b0, 1'b1, 32'h27, 32'hFFFF1234, 2'd1, lat, bcyc);
        do_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd0, lat, bcyc);
        check_val("merge_lane", do0, {64'h0, 64'h1234_0000_AA00_0000});

        // Simultaneous rd/wr: read wins, lane untouched until write re-presented
        zero_lane(1'b0, 32'h40);
        do_req(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2'd2, lat, bcyc);
        check_val("rdwr_read_lane", do0, 128'd0);
        check_val("rdwr_latency", 128'(lat), 128'd4);
        do_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, lat, bcyc);
        check_val("rdwr_lane_unchanged", do0, 128'd0);
        do_req(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'd3, lat, bcyc);
        do_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, lat, bcyc);
        check_val("rewrite_commit", do0, {96'h0, 32'hCAFEF00D});

        // Reset two cycles into a write aborts it
        zero_lane(1'b0, 32'h50);
        do_req(1'b0, 1'b0, 1'b1, 32'h50, 32'h22222222, 2'd2, lat, bcyc);
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h50; wd0 = 32'h11111111; wt0 = 2'd2;
        seen_rdy = 1'b0;
        @(negedge clk);
        check_val("midrst_busy_before", 128'(busy0), 128'd1);
        seen_rdy = seen_rdy | rdy0;
        @(negedge clk);
        seen_rdy = seen_rdy | rdy0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr0 = 1'b0;
        check_val("midrst_busy_after", 128'(busy0), 128'd0);
        check_val("midrst_data_cleared", do0, 128'd0);
        seen_rdy = seen_rdy | rdy0;
        repeat (6) begin
            @(negedge clk);
            seen_rdy = seen_rdy | rdy0;
        end
        check_val("midrst_no_rdy", 128'(seen_rdy), 128'd0);
        do_req(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 2'd0, lat, bcyc);
        check_val("midrst_old_value", do0, {96'h0, 32'h22222222});

        // Address wrap: 0x4000 aliases lane 0
        do_req(1'b0, 1'b0, 1'b1, 32'h4000, 32'h00000055, 2'd0, lat, bcyc);
        do_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, lat, bcyc);
        check_val("wrap_byte0", 128'(do0[7:0]), 128'h55);

        // LATENCY=1 instance
        do_req(1'b1, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 2'd2, lat, bcyc);
        check_val("l1_wr_latency", 128'(lat), 128'd1);
        check_val("l1_wr_busy_cycles", 128'(bcyc), 128'd1);
        do_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 2'd0, lat, bcyc);
        check_val("l1_rd_latency", 128'(lat), 128'd1);
        check_val("l1_rd_word", 128'(do1[31:0]), 128'hA5A5A5A5);

        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h30;
        rdy_pat = '0; busy_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rdy_pat[i]  = rdy1;
            busy_pat[i] = busy1;
        end
        rd1 = 1'b0;
        check_val("l1_b2b_rdy", 128'(rdy_pat), 128'(6'b010101));
        check_val("l1_b2b_busy", 128'(busy_pat), 128'(6'b010101));
        check_val("l1_b2b_data", 128'(do1[31:0]), 128'hA5A5A5A5);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
